// File: rtl/eprisc_bus_pkg.sv
// rtl/eprisc_bus_pkg.sv - shared states and command constants for the epRISC bus responder
package eprisc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMMAND = 3'd1,
        ST_WRDATA  = 3'd2,
        ST_RDDATA  = 3'd3,
        ST_DONE    = 3'd4
    } bus_state_e;

    // Command byte fields (bit 0 = MSB on the wire)
    localparam int CMD_WRITE_BIT = 0;
    localparam int CMD_ACK_BIT   = 1;
    localparam int CMD_ADDR_BIT  = 4;

    localparam logic [1:0] SEL_IDLE = 2'h0;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [1:0]  LAST_BYTE  = 2'(WORD_BYTES - 1);

endpackage

// File: rtl/eprisc_bus_sync.sv
// rtl/eprisc_bus_sync.sv - bus pin synchronizers and bus clock edge events
module eprisc_bus_sync
    import eprisc_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_clk,
    input  logic [0:1]  bus_sel,
    input  logic [0:7]  bus_mosi,
    output logic        clk_rise,
    output logic        clk_fall,
    output logic [0:1]  sel_sync,
    output logic [0:7]  mosi_sync
);

    logic       clk_meta_q, clk_meta_d;
    logic       clk_sync_q, clk_sync_d;
    logic       clk_prev_q, clk_prev_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;
    logic [0:1] sel_meta_q, sel_meta_d;
    logic [0:1] sel_sync_q, sel_sync_d;
    logic [0:7] mosi_meta_q, mosi_meta_d;
    logic [0:7] mosi_sync_q, mosi_sync_d;

    // Two-stage synchronizers, then a registered edge detector on the bus clock
    always_comb begin
        clk_meta_d  = bus_clk;
        clk_sync_d  = clk_meta_q;
        clk_prev_d  = clk_sync_q;
        rise_d      = clk_sync_q & ~clk_prev_q;
        fall_d      = ~clk_sync_q & clk_prev_q;
        sel_meta_d  = bus_sel;
        sel_sync_d  = sel_meta_q;
        mosi_meta_d = bus_mosi;
        mosi_sync_d = mosi_meta_q;
    end

    // Synchronizer and edge-event registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q  <= 1'b0;
            clk_sync_q  <= 1'b0;
            clk_prev_q  <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            sel_meta_q  <= SEL_IDLE;
            sel_sync_q  <= SEL_IDLE;
            mosi_meta_q <= 8'h00;
            mosi_sync_q <= 8'h00;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            clk_prev_q  <= clk_prev_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            sel_meta_q  <= sel_meta_d;
            sel_sync_q  <= sel_sync_d;
            mosi_meta_q <= mosi_meta_d;
            mosi_sync_q <= mosi_sync_d;
        end
    end

    assign clk_rise  = rise_q;
    assign clk_fall  = fall_q;
    assign sel_sync  = sel_sync_q;
    assign mosi_sync = mosi_sync_q;

endmodule

// File: rtl/eprisc_bus_responder.sv
// rtl/eprisc_bus_responder.sv - epRISC expansion bus endpoint turning frames into register accesses
module eprisc_bus_responder
    import eprisc_bus_pkg::*;
#(
    parameter logic [1:0] pSelectCode = 2'h1
) (
    input  logic        iBoardClock,
    input  logic        iBoardReset,
    input  logic        iBusClock,
    input  logic [0:1]  iBusSelect,
    input  logic [0:7]  iBusMOSI,
    output logic [0:7]  oBusMISO,
    output logic        oBusMISOEnable,
    output logic        oBusInterrupt,
    output logic [0:3]  oRegAddress,
    output logic [0:31] oRegWriteData,
    output logic        oRegWrite,
    output logic        oRegRead,
    input  logic [0:31] iRegReadData,
    input  logic        iIrqRequest
);

    logic       bus_rise;
    logic       bus_fall;
    logic [0:1] bus_sel;
    logic [0:7] bus_mosi;
    logic       selected;
    logic       irq_ack;

    bus_state_e  state_q, state_d;
    logic [0:3]  addr_q, addr_d;
    logic [0:31] wdata_q, wdata_d;
    logic [0:31] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [0:7]  miso_q, miso_d;
    logic        miso_en_q, miso_en_d;
    logic        reg_write_q, reg_write_d;
    logic        reg_read_q, reg_read_d;
    logic        rd_cap_q, rd_cap_d;
    logic        irq_pend_q, irq_pend_d;

    eprisc_bus_sync u_sync (
        .clk       (iBoardClock),
        .rst       (iBoardReset),
        .bus_clk   (iBusClock),
        .bus_sel   (iBusSelect),
        .bus_mosi  (iBusMOSI),
        .clk_rise  (bus_rise),
        .clk_fall  (bus_fall),
        .sel_sync  (bus_sel),
        .mosi_sync (bus_mosi)
    );

    // A zero select code means the bus is idle, so it never counts as a match
    assign selected = (bus_sel == pSelectCode) && (bus_sel != SEL_IDLE);

    // Frame decoder: next state, strobes, shift registers and MISO
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        miso_d      = miso_q;
        miso_en_d   = miso_en_q;
        reg_write_d = 1'b0;
        reg_read_d  = 1'b0;
        rd_cap_d    = 1'b0;
        irq_ack     = 1'b0;

        if (!selected) begin
            state_d   = ST_IDLE;
            cnt_d     = 2'd0;
            miso_en_d = 1'b0;
            miso_d    = 8'h00;
        end else begin
            // Register file answers one cycle after the read strobe
            rd_cap_d = reg_read_q;
            if (rd_cap_q) begin
                shift_d = iRegReadData;
            end

            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COMMAND;
                end
                ST_COMMAND: begin
                    if (bus_rise) begin
                        addr_d  = bus_mosi[CMD_ADDR_BIT +: 4];
                        irq_ack = bus_mosi[CMD_ACK_BIT];
                        cnt_d   = 2'd0;
                        if (bus_mosi[CMD_WRITE_BIT]) begin
                            state_d = ST_WRDATA;
                        end else begin
                            reg_read_d = 1'b1;
                            miso_en_d  = 1'b1;
                            state_d    = ST_RDDATA;
                        end
                    end
                end
                ST_WRDATA: begin
                    if (bus_rise) begin
                        wdata_d = {wdata_q[8:31], bus_mosi};
                        cnt_d   = cnt_q + 2'd1;
                        if (cnt_q == LAST_BYTE) begin
                            reg_write_d = 1'b1;
                            state_d     = ST_DONE;
                        end
                    end
                end
                ST_RDDATA: begin
                    if (bus_fall) begin
                        miso_d  = shift_q[0:7];
                        shift_d = {shift_q[8:31], 8'h00};
                    end
                    if (bus_rise) begin
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == LAST_BYTE) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus_fall) begin
                        miso_d = 8'h00;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A request arriving in the same cycle as an acknowledge is kept
        irq_pend_d = iIrqRequest | (irq_pend_q & ~irq_ack);
    end

    // Frame state and output registers
    always_ff @(posedge iBoardClock or posedge iBoardReset) begin
        if (iBoardReset) begin
            state_q     <= ST_IDLE;
            addr_q      <= 4'h0;
            wdata_q     <= 32'h0000_0000;
            shift_q     <= 32'h0000_0000;
            cnt_q       <= 2'd0;
            miso_q      <= 8'h00;
            miso_en_q   <= 1'b0;
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            rd_cap_q    <= 1'b0;
            irq_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
            miso_en_q   <= miso_en_d;
            reg_write_q <= reg_write_d;
            reg_read_q  <= reg_read_d;
            rd_cap_q    <= rd_cap_d;
            irq_pend_q  <= irq_pend_d;
        end
    end

    assign oBusMISO       = miso_q;
    assign oBusMISOEnable = miso_en_q;
    assign oBusInterrupt  = irq_pend_q;
    assign oRegAddress    = addr_q;
    assign oRegWriteData  = wdata_q;
    assign oRegWrite      = reg_write_q;
    assign oRegRead       = reg_read_q;

endmodule

// File: tb/tb_eprisc_bus_responder.sv
// tb/tb_eprisc_bus_responder.sv - directed self-checking bench for eprisc_bus_responder
module tb_eprisc_bus_responder;

    localparam int PHASE = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        iBusClock;
    logic [0:1]  iBusSelect;
    logic [0:7]  iBusMOSI;
    logic [0:7]  oBusMISO;
    logic        oBusMISOEnable;
    logic        oBusInterrupt;
    logic [0:3]  oRegAddress;
    logic [0:31] oRegWriteData;
    logic        oRegWrite;
    logic        oRegRead;
    logic [0:31] iRegReadData;
    logic        iIrqRequest;

    logic [31:0] regval;
    logic [7:0]  tx [5];
    logic [7:0]  rx [5];

    int errors = 0;
    int checks = 0;

    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          en_cnt = 0;
    logic [3:0]  wr_addr_at = 4'h0;
    logic [31:0] wr_data_at = 32'h0;
    logic [3:0]  rd_addr_at = 4'h0;

    int wr0, rd0, en0;

    eprisc_bus_responder #(.pSelectCode(2'h1)) dut (
        .iBoardClock    (clk),
        .iBoardReset    (rst),
        .iBusClock      (iBusClock),
        .iBusSelect     (iBusSelect),
        .iBusMOSI       (iBusMOSI),
        .oBusMISO       (oBusMISO),
        .oBusMISOEnable (oBusMISOEnable),
        .oBusInterrupt  (oBusInterrupt),
        .oRegAddress    (oRegAddress),
        .oRegWriteData  (oRegWriteData),
        .oRegWrite      (oRegWrite),
        .oRegRead       (oRegRead),
        .iRegReadData   (iRegReadData),
        .iIrqRequest    (iIrqRequest)
    );

    always #5 clk = ~clk;

    // Register file model: read data is valid only in the cycle after the strobe
    always @(posedge clk) begin
        iRegReadData <= oRegRead ? regval : 32'hA5A5_A5A5;
    end

    // Strobe and enable observers
    always @(negedge clk) begin
        if (oRegWrite) begin
            wr_cnt     = wr_cnt + 1;
            wr_addr_at = oRegAddress;
            wr_data_at = oRegWriteData;
        end
        if (oRegRead) begin
            rd_cnt     = rd_cnt + 1;
            rd_addr_at = oRegAddress;
        end
        if (oBusMISOEnable) begin
            en_cnt = en_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] miso_at_rise);
        iBusMOSI = b;
        repeat (PHASE) @(negedge clk);
        miso_at_rise = oBusMISO;
        iBusClock = 1'b1;
        repeat (PHASE) @(negedge clk);
        iBusClock = 1'b0;
    endtask

    task automatic do_frame(input logic [1:0] sel, input int nbytes, input bit deselect_after);
        iBusSelect = sel;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(tx[i], rx[i]);
        end
        repeat (PHASE) @(negedge clk);
        if (deselect_after) begin
            iBusSelect = 2'h0;
            repeat (6) @(negedge clk);
        end
    endtask

    // IRQ-acknowledge command byte; optionally raise the request exactly in the decode cycle
    task automatic ack_frame(input bit req_on_ack);
        iBusSelect = 2'h1;
        repeat (4) @(negedge clk);
        iBusMOSI = 8'h40;
        repeat (PHASE) @(negedge clk);
        iBusClock = 1'b1;
        repeat (3) @(negedge clk);
        if (req_on_ack) iIrqRequest = 1'b1;
        @(negedge clk);
        iIrqRequest = 1'b0;
        repeat (PHASE) @(negedge clk);
        iBusClock = 1'b0;
        repeat (PHASE) @(negedge clk);
        iBusSelect = 2'h0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        iBusClock   = 1'b0;
        iBusSelect  = 2'h0;
        iBusMOSI    = 8'h00;
        iIrqRequest = 1'b0;
        regval      = 32'h1234_5678;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_miso",   32'(oBusMISO), 32'h0);
        chk("rst_en",     32'(oBusMISOEnable), 32'h0);
        chk("rst_irq",    32'(oBusInterrupt), 32'h0);
        chk("rst_addr",   32'(oRegAddress), 32'h0);
        chk("rst_wdata",  32'(oRegWriteData), 32'h0);
        chk("rst_write",  32'(oRegWrite), 32'h0);
        chk("rst_read",   32'(oRegRead), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write frame to register 3
        wr0 = wr_cnt; rd0 = rd_cnt; en0 = en_cnt;
        tx[0] = 8'h83; tx[1] = 8'hDE; tx[2] = 8'hAD; tx[3] = 8'hBE; tx[4] = 8'hEF;
        do_frame(2'h1, 5, 1'b1);
        chk("wr_strobes",  32'(wr_cnt - wr0), 32'd1);
        chk("wr_no_read",  32'(rd_cnt - rd0), 32'd0);
        chk("wr_addr",     32'(wr_addr_at), 32'h3);
        chk("wr_data",     wr_data_at, 32'hDEAD_BEEF);
        chk("wr_no_en",    32'(en_cnt - en0), 32'd0);
        chk("wr_addr_hold", 32'(oRegAddress), 32'h3);

        // Read frame from register 5
        wr0 = wr_cnt; rd0 = rd_cnt;
        regval = 32'h1234_5678;
        tx[0] = 8'h05; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h00; tx[4] = 8'h00;
        do_frame(2'h1, 5, 1'b0);
        chk("rd_strobes", 32'(rd_cnt - rd0), 32'd1);
        chk("rd_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("rd_addr",    32'(rd_addr_at), 32'h5);
        chk("rd_byte1",   32'(rx[1]), 32'h12);
        chk("rd_byte2",   32'(rx[2]), 32'h34);
        chk("rd_byte3",   32'(rx[3]), 32'h56);
        chk("rd_byte4",   32'(rx[4]), 32'h78);
        chk("rd_en_done", 32'(oBusMISOEnable), 32'h1);
        iBusSelect = 2'h0;
        repeat (4) @(negedge clk);
        chk("rd_en_off",  32'(oBusMISOEnable), 32'h0);
        chk("rd_miso_off", 32'(oBusMISO), 32'h0);
        repeat (4) @(negedge clk);

        // Aborted write: command plus two data bytes then deselect
        wr0 = wr_cnt; en0 = en_cnt;
        tx[0] = 8'h82; tx[1] = 8'h11; tx[2] = 8'h22;
        do_frame(2'h1, 3, 1'b1);
        chk("abort_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("abort_en",       32'(oBusMISOEnable), 32'h0);

        // Foreign select code
        wr0 = wr_cnt; rd0 = rd_cnt; en0 = en_cnt;
        tx[0] = 8'h83; tx[1] = 8'h01; tx[2] = 8'h02; tx[3] = 8'h03; tx[4] = 8'h04;
        do_frame(2'h2, 5, 1'b1);
        chk("foreign_no_write", 32'(wr_cnt - wr0), 32'd0);
        chk("foreign_no_read",  32'(rd_cnt - rd0), 32'd0);
        chk("foreign_no_en",    32'(en_cnt - en0), 32'd0);

        // Interrupt set and acknowledge
        chk("irq_idle", 32'(oBusInterrupt), 32'h0);
        iIrqRequest = 1'b1;
        @(negedge clk);
        iIrqRequest = 1'b0;
        chk("irq_set", 32'(oBusInterrupt), 32'h1);
        repeat (5) @(negedge clk);
        chk("irq_held", 32'(oBusInterrupt), 32'h1);
        ack_frame(1'b0);
        chk("irq_acked", 32'(oBusInterrupt), 32'h0);
        iIrqRequest = 1'b1;
        @(negedge clk);
        iIrqRequest = 1'b0;
        chk("irq_set2", 32'(oBusInterrupt), 32'h1);
        ack_frame(1'b1);
        chk("irq_set_wins", 32'(oBusInterrupt), 32'h1);

        // Reset in the middle of a read frame, after data byte 2
        regval = 32'h1234_5678;
        tx[0] = 8'h05; tx[1] = 8'h00; tx[2] = 8'h00;
        do_frame(2'h1, 3, 1'b0);
        chk("mid_byte1", 32'(rx[1]), 32'h12);
        chk("mid_byte2", 32'(rx[2]), 32'h34);
        rst = 1'b1;
        #1;
        chk("mid_rst_miso",  32'(oBusMISO), 32'h0);
        chk("mid_rst_en",    32'(oBusMISOEnable), 32'h0);
        chk("mid_rst_irq",   32'(oBusInterrupt), 32'h0);
        chk("mid_rst_addr",  32'(oRegAddress), 32'h0);
        chk("mid_rst_wdata", 32'(oRegWriteData), 32'h0);
        chk("mid_rst_write", 32'(oRegWrite), 32'h0);
        chk("mid_rst_read",  32'(oRegRead), 32'h0);
        iBusSelect = 2'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Fresh read after reset
        rd0 = rd_cnt;
        regval = 32'h9ABC_DEF0;
        tx[0] = 8'h05; tx[1] = 8'h00; tx[2] = 8'h00; tx[3] = 8'h00; tx[4] = 8'h00;
        do_frame(2'h1, 5, 1'b1);
        chk("post_rd_strobes", 32'(rd_cnt - rd0), 32'd1);
        chk("post_rd_addr",    32'(rd_addr_at), 32'h5);
        chk("post_byte1",      32'(rx[1]), 32'h9A);
        chk("post_byte2",      32'(rx[2]), 32'hBC);
        chk("post_byte3",      32'(rx[3]), 32'hDE);
        chk("post_byte4",      32'(rx[4]), 32'hF0);
        chk("post_en_off",     32'(oBusMISOEnable), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eprisc_bus_responder.md
# eprisc_bus_responder

Peripheral-side endpoint of the epRISC 8-bit expansion bus; the machine's bus master drives clock, select and MOSI. The block oversamples the bus in its own clock domain, decodes a command byte plus four data bytes, and turns each frame into one local register read or write. It returns read data on MISO and raises the shared bus interrupt on local request. One instance per expansion card, between the bus connector and the card's register file.

## Interface
- pSelectCode, 2'h1, select code this responder answers to; must be nonzero (2'h0 = bus idle)
- iBoardClock  in  1  card clock, all logic on rising edge
- iBoardReset  in  1  asynchronous, active-high reset
- iBusClock  in  1  bus clock from master, asynchronous to iBoardClock
- iBusSelect  in  [0:1]  device select, 2'h0 idle
- iBusMOSI  in  [0:7]  master-to-device byte
- oBusMISO  out  [0:7]  device-to-master byte
- oBusMISOEnable  out  1  high while this device owns MISO (drives board tri-state)
- oBusInterrupt  out  1  pending-interrupt level to master
- oRegAddress  out  [0:3]  local register address
- oRegWriteData  out  [0:31]  local write data
- oRegWrite  out  1  one-cycle write strobe
- oRegRead  out  1  one-cycle read strobe
- iRegReadData  in  [0:31]  read data, valid exactly 1 cycle after oRegRead
- iIrqRequest  in  1  local interrupt request, sampled each cycle

## Operation
- All vectors bit 0 = MSB; bytes sent MSB-first, words big-endian (byte 1 = bits 0:7).
- iBusClock, iBusSelect, iBusMOSI pass a 2-flop synchronizer; rising/falling edges of synchronized clock become one-cycle events. MOSI sampled on rise events only.
- Selected = synchronized select equals pSelectCode.
- Command byte: bit 0 = write(1)/read(0), bit 1 = IRQ acknowledge, bits 2:3 reserved (ignored), bits 4:7 = register address.
- States: IDLE, COMMAND, WRDATA, RDDATA, DONE.
- IDLE -> COMMAND when selected.
- COMMAND: on first rise, latch address to oRegAddress; write -> WRDATA; read -> pulse oRegRead next cycle, capture iRegReadData one cycle later into shift register, -> RDDATA; IRQ ack bit clears pending interrupt in either case.
- WRDATA: 2-bit counter collects 4 bytes into oRegWriteData; after 4th, pulse oRegWrite once, -> DONE.
- RDDATA: oBusMISOEnable high; on each fall event load next byte (bytes 1..4) onto oBusMISO; after 4th byte's rise -> DONE.
- DONE: further bytes ignored, MISO 8'h00 (enable stays high for read frames); -> IDLE on deselect.
- Deselect in any state -> IDLE next cycle, counter cleared, enable low, MISO 8'h00, no pending strobe issued (aborted write never strobes).
- Interrupt: pending flag set when iIrqRequest high; cleared by ack; set and clear same cycle -> set wins. oBusInterrupt = pending flag, registered.
- Reset values: all outputs 0, state IDLE, pending clear, counter 0.

## Timing
- Bus event latency: 3 iBoardClock cycles from pin edge to internal event (2 sync + edge register).
- Bus clock high and low phases each ≥4 iBoardClock cycles; guarantees read data is in shift register before first fall event after command.
- oRegRead: cycle after command-byte rise event; data captured following cycle.
- oRegWrite: cycle after 4th data-byte rise event; address/data stable from strobe until next frame's command.
- oBusMISO changes only on fall events; stable across the following master rising edge.
- Reset mid-frame: immediate return to reset values; no strobe; next frame decoded normally.

## Structure
- Package eprisc_bus_pkg: state enum, command bit positions, idle select code 2'h0, word-bytes constant 4.
- Sub-module eprisc_bus_sync: 2-flop synchronizer plus rise/fall edge detector for clock, and synchronizers for select/MOSI; instantiated once.

## Test plan
- Write: select 1, bytes 0x83,0xDE,0xAD,0xBE,0xEF -> single oRegWrite, oRegAddress 3, oRegWriteData 0xDEADBEEF; no oRegRead.
- Read: bytes 0x05 then 4 dummies, iRegReadData 0x12345678 -> one oRegRead addr 5; MISO 0x12,0x34,0x56,0x78 at master rises of bytes 1..4; enable low within 4 cycles of deselect.
- Abort: write command 0x82 plus 2 data bytes, then deselect -> no oRegWrite, state IDLE, enable 0.
- Foreign select 2'h2 with write frame -> no strobes, enable never high.
- IRQ: pulse iIrqRequest -> oBusInterrupt 1 next cycle; frame 0x40 clears it; repeat with iIrqRequest high on ack cycle -> stays 1.
- Reset asserted mid-read after byte 2 -> all outputs 0 immediately; subsequent read of addr 5 returns correct bytes.
